muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide execution unit, issued by the execute stage alongside the single-cycle ALU. It accepts two 32-bit operands and a 3-bit funct3 opcode on a start pulse. It iterates one bit per cycle and returns a registered 32-bit result with ALU-style Zero/Negative flags and a one-cycle done pulse. While busy, the hazard unit stalls the pipeline.

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_FAST_PATH_EN: divide-by-zero, signed overflow and zero-operand multiply skip CALC.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   a_orig_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic               sign_a_reg, sign_b_reg;
  logic               b_zero_reg, ovf_reg, mul_zero_reg;
  logic               done_reg, zero_reg, neg_reg;
  logic [WIDTH-1:0]   result_reg;

  // Operand decode at accept time
  logic             accept;
  logic             sign_a_in, sign_b_in;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             b_zero_in, ovf_in, mul_zero_in;

  assign accept    = (state_reg == IDLE) && start && !done_reg;
  assign sign_a_in = (op[2] ? ~op[0] : (op[1:0] != 2'b11)) & SrcA[WIDTH-1];
  assign sign_b_in = (op[2] ? ~op[0] : ~op[1]) & SrcB[WIDTH-1];
  assign a_abs     = sign_a_in ? -SrcA : SrcA;
  assign b_abs     = sign_b_in ? -SrcB : SrcB;
  assign b_zero_in   = (SrcB == '0);
  assign ovf_in      = ~op[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == {WIDTH{1'b1}});
  assign mul_zero_in = (SrcA == '0) || b_zero_in;

  // One iteration of each algorithm; acc holds {product} or {remainder, quotient}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_reg};
  assign div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

  // Sign correction and special-case overrides applied in DONE
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   mul_res, quot_fix, rem_fix, final_res;

  always_comb begin
    prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
    mul_res  = (op_reg[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    if (mul_zero_reg) mul_res = '0;
    quot_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    if (b_zero_reg) begin
      quot_fix = {WIDTH{1'b1}};
      rem_fix  = a_orig_reg;
    end else if (ovf_reg) begin
      quot_fix = {1'b1, {(WIDTH-1){1'b0}}};
      rem_fix  = '0;
    end
    final_res = op_reg[2] ? (op_reg[1] ? rem_fix : quot_fix) : mul_res;
  end

`ifdef MULDIV_FAST_PATH_EN
  logic fast_in;
  assign fast_in = op[2] ? (b_zero_in || ovf_in) : mul_zero_in;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
`ifdef MULDIV_FAST_PATH_EN
          state_next = fast_in ? DONE : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    if (cnt_reg == CW'(WIDTH-1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      a_orig_reg   <= '0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      b_zero_reg   <= 1'b0;
      ovf_reg      <= 1'b0;
      mul_zero_reg <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      zero_reg     <= 1'b0;
      neg_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == DONE);
      if (accept) begin
        op_reg       <= op;
        a_orig_reg   <= SrcA;
        sign_a_reg   <= sign_a_in;
        sign_b_reg   <= sign_b_in;
        b_zero_reg   <= b_zero_in;
        ovf_reg      <= ovf_in;
        mul_zero_reg <= mul_zero_in;
        cnt_reg      <= '0;
        opnd_reg     <= op[2] ? b_abs : a_abs;
        acc_reg      <= {{WIDTH{1'b0}}, op[2] ? a_abs : b_abs};
      end else if (state_reg == CALC) begin
        cnt_reg <= cnt_reg + 1'b1;
        acc_reg <= op_reg[2] ? div_next : mul_next;
      end
      if (state_reg == DONE) begin
        result_reg <= final_res;
        zero_reg   <= (final_res == '0);
        neg_reg    <= final_res[WIDTH-1];
      end
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign Result   = result_reg;
  assign Zero     = zero_reg;
  assign Negative = neg_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency/busy checks, ignored start and mid-op reset.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
`ifdef MULDIV_FAST_PATH_EN
  localparam int SL = 1;
`else
  localparam int SL = 33;
`endif

  logic        clk, rst_n, start;
  logic [2:0]  op;
  logic [31:0] srca, srcb;
  logic        busy, done, zero, negative;
  logic [31:0] result;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .SrcA(srca), .SrcB(srcb),
    .busy(busy), .done(done), .Result(result), .Zero(zero), .Negative(negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d: Result=0x%08h, no operation outstanding", cyc, result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_zero"}, {31'b0, zero}, {31'b0, e.res == 32'h0});
        chk({e.name, "_negative"}, {31'b0, negative}, {31'b0, e.res[31]});
        chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
        $display("txn %-12s Result=0x%08h Z=%0b N=%0b latency=%0d", e.name, result, zero, negative, cyc - e.t0);
      end
    end
  end

  // Issue one operation; optionally pulse a competing start glitch_at cycles after accept
  task automatic issue(string nm, logic [2:0] o, logic [31:0] a, logic [31:0] b,
                       logic [31:0] r, int lat, int glitch_at);
    exp_t e;
    int   k;
    bit   busy_bad;
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    e.name = nm; e.res = r; e.lat = lat; e.t0 = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk); #1;
    start = 1'b0; op = OP_MULHU; srca = 32'hDEADBEEF; srcb = 32'h12345678;
    busy_bad = 1'b0;
    k = 1;
    while (sb_q.size() != 0 && k < 100) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (k == glitch_at) begin
        start = 1'b1; op = OP_MUL; srca = 32'd3; srcb = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles, required done after %0d", nm, k, lat);
      sb_q.delete();
    end
    chk({nm, "_busy"}, {31'b0, busy_bad | busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(string nm);
    chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
    chk({nm, "_done"}, {31'b0, done}, 32'd0);
    chk({nm, "_result"}, result, 32'h0);
    chk({nm, "_zero"}, {31'b0, zero}, 32'd0);
    chk({nm, "_negative"}, {31'b0, negative}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'b000; srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;

    issue("mul_7_m3",     OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    issue("mulhu_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    issue("mulh_min_2",   OP_MULH,   32'h80000000, 32'd2,        32'hFFFFFFFF, 33, 0);
    issue("mulhsu_m1",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
    issue("mul_zero",     OP_MUL,    32'd0,        32'd12345,    32'h00000000, SL, 0);
    issue("div_m20_3",    OP_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33, 0);
    issue("rem_m20_3",    OP_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33, 0);
    issue("divu_100_7",   OP_DIVU,   32'd100,      32'd7,        32'd14,       33, 0);
    issue("remu_100_7",   OP_REMU,   32'd100,      32'd7,        32'd2,        33, 0);
    issue("rem_21_7",     OP_REM,    32'd21,       32'd7,        32'd0,        33, 0);
    issue("divu_5_0",     OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SL, 0);
    issue("rem_5_0",      OP_REM,    32'd5,        32'd0,        32'd5,        SL, 0);
    issue("div_m5_0",     OP_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SL, 0);
    issue("div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SL, 0);
    issue("rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, SL, 0);
    issue("rem_m5_0",     OP_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SL, 0);

    // Mid-operation reset: outputs clear at once and the dropped MUL never completes
    @(negedge clk);
    start = 1'b1; op = OP_MUL; srca = 32'd1234; srcb = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue("mul_6_7",      OP_MUL,    32'd6,        32'd7,        32'd42,       33, 0);
    issue("divu_ignore",  OP_DIVU,   32'd100,      32'd7,        32'd14,       33, 10);
    repeat (40) @(negedge clk);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding: %0d operations still queued, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
